conv1_layer1_out_collector: RTL

//  Write-side counterpart of the global input-feature reader for conv1_layer1 dense.

---
 rtl/conv1_layer1_out_collector.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/conv1_layer1_out_collector.sv
// conv1_layer1_out_collector
// Write-side collector for the conv1_layer1 dense stage. It issues need_data
// requests upstream, gated by a credit counter, and collects the adder-tree
// results. Every LANES results are packed into one output word, which is then
// written to the output-feature BRAM.
module conv1_layer1_out_collector #(
  parameter int DATA_W       = 16,
  parameter int LANES        = 25,
  parameter int DEPTH        = 1024,
  parameter int ADDR_W       = 10,
  parameter int MAX_INFLIGHT = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    res_v,
  input  logic [DATA_W-1:0]       res_data,
  output logic                    need_data,
  output logic                    wr_en,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic [LANES*DATA_W-1:0] wr_data,
  output logic                    busy,
  output logic                    done,
  output logic                    ovf_err
);

  localparam int TOTAL  = DEPTH * LANES;
  localparam int REQ_W  = $clog2(TOTAL + 1);
  localparam int CRED_W = $clog2(MAX_INFLIGHT + 1);
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int WORD_W = LANES * DATA_W;

  localparam logic [REQ_W-1:0]  REQ_TOTAL = REQ_W'(TOTAL);
  localparam logic [CRED_W-1:0] CRED_MAX  = CRED_W'(MAX_INFLIGHT);
  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(LANES - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state;
  logic [CRED_W-1:0] credits;
  logic [REQ_W-1:0]  req_cnt;
  logic [LANE_W-1:0] lane_cnt;
  logic [ADDR_W-1:0] word_cnt;
  logic [WORD_W-1:0] pack;

  logic              req_go;
  logic              res_ok;
  logic              res_bad;
  logic              last_lane;
  logic              last_word_wr;
  logic [WORD_W-1:0] pack_next;

  // Request/accept qualification and the pack word including the incoming lane
  always_comb begin
    req_go       = (state == S_RUN) && (credits != '0) && (req_cnt != REQ_TOTAL);
    res_ok       = res_v && ((state == S_RUN) || (state == S_DRAIN)) && (credits != CRED_MAX);
    res_bad      = res_v && !res_ok;
    last_lane    = (lane_cnt == LANE_LAST);
    last_word_wr = wr_en && (wr_addr == ADDR_LAST);
    pack_next    = pack;
    pack_next[int'(lane_cnt)*DATA_W +: DATA_W] = res_data;
  end

  // Status outputs decoded from the FSM state and request qualifier
  always_comb begin
    need_data = req_go;
    busy      = (state == S_RUN) || (state == S_DRAIN);
    done      = (state == S_DONE);
  end

  // FSM, credit/request counters, lane packing and BRAM write port
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      credits  <= CRED_MAX;
      req_cnt  <= '0;
      lane_cnt <= '0;
      word_cnt <= '0;
      pack     <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      ovf_err  <= 1'b0;
    end else begin
      wr_en <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_RUN;
            credits  <= CRED_MAX;
            req_cnt  <= '0;
            lane_cnt <= '0;
            word_cnt <= '0;
            pack     <= '0;
            ovf_err  <= 1'b0;
          end
        end
        S_RUN: begin
          // A zero-latency upstream can finish the last word before RUN exits
          if (last_word_wr)
            state <= S_DONE;
          else if (req_cnt == REQ_TOTAL)
            state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (last_word_wr)
            state <= S_DONE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase

      // Simultaneous request and accepted result cancel out
      if (req_go && !res_ok)
        credits <= credits - 1'b1;
      else if (res_ok && !req_go)
        credits <= credits + 1'b1;

      if (req_go)
        req_cnt <= req_cnt + 1'b1;

      if (res_ok) begin
        if (last_lane) begin
          wr_en    <= 1'b1;
          wr_addr  <= word_cnt;
          wr_data  <= pack_next;
          word_cnt <= word_cnt + 1'b1;
          lane_cnt <= '0;
        end else begin
          lane_cnt <= lane_cnt + 1'b1;
        end
        pack <= pack_next;
      end

      // Set after the IDLE clear so a stray result always leaves a mark
      if (res_bad)
        ovf_err <= 1'b1;
    end
  end

endmodule
